apb_master_dec: RTL and testbench
=================================

APB_MASTER_DEC -- requirements
Module: apb_master_dec

Interface
REQ-001 Parameter ADDR_W, default 32, address width of addr and PADDR.
REQ-002 Parameter DATA_W, default 32, data width of wdata, rdata, PWDATA and each PRDATA lane.
REQ-003 Parameter NUM_SLV, default 4, number of APB completers; legal range 1-16.
REQ-004 Parameter BASE_ADDR, default 32'h1000_0000, start of the decoded region.
REQ-005 Parameter SLV_SHIFT, default 12, log2 of the window size per completer (4 KiB).
REQ-006 Parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-007 The ports SHALL be:
- PCLK  in  1  clock
- PRESET  in  1  reset
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PWRITE  out  1  1=write, 0=read
- PENABLE  out  1  APB access phase
- PSEL  out  NUM_SLV  one-hot completer select
- PRDATA  in  NUM_SLV*DATA_W  read data; lane i is bits [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  per-completer ready
- PSLVERR  in  NUM_SLV  per-completer error
- transfer  in  1  request strobe from CPU
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  request write data
- write  in  1  1=write, 0=read
- ready  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result
- error  out  1  completion status, valid with ready
- busy  out  1  request in flight
REQ-008 Reset is PRESET, asynchronous, active-high; clock is PCLK.

Function
REQ-009 The FSM SHALL have three states: IDLE, SETUP and ACCESS; busy=1 in SETUP and ACCESS.
REQ-010 In IDLE with transfer=1, the block SHALL latch addr, write and wdata (wdata latched as 0 on reads) plus the decoded index.
REQ-011 transfer SHALL be ignored in SETUP and ACCESS.
REQ-012 Decode rule:
- idx = (addr - BASE_ADDR) >> SLV_SHIFT.
- An address is valid iff addr >= BASE_ADDR and idx < NUM_SLV.
REQ-013 Valid request: IDLE->SETUP on the next edge.
REQ-014 Invalid request: remain in IDLE, assert no PSEL bit, and on the next cycle drive ready=1, error=1 and rdata=0.
REQ-015 PADDR, PWRITE and PWDATA SHALL be registered, update only on request acceptance, and hold their values between transfers.
REQ-016 In SETUP: PSEL[idx]=1, PENABLE=0; SETUP->ACCESS unconditionally after one cycle.
REQ-017 In ACCESS: PSEL[idx]=1, PENABLE=1; the block SHALL sample only PREADY[idx] and PSLVERR[idx].
REQ-018 On the ACCESS edge with PREADY[idx]=1, completion SHALL occur:
- next state IDLE;
- the next cycle drives ready=1 for exactly one cycle and error=PSLVERR[idx];
- on a read, rdata=PRDATA lane idx, or 0 if PSLVERR=1;
- on a write, rdata holds its previous value.
REQ-019 The timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY[idx]=0.
REQ-020 When the counter reaches TIMEOUT_CYC, with TIMEOUT_CYC != 0, the block SHALL abort: next state IDLE, then ready=1, error=1 and rdata=0 on reads.
REQ-021 Minimum valid transfer latency: transfer in cycle 0 -> SETUP in cycle 1 -> ACCESS in cycle 2 -> ready in cycle 3 (zero wait states).
REQ-022 A new transfer SHALL be accepted in the same cycle that ready=1 (the FSM is in IDLE).
REQ-023 PSEL SHALL never have more than one bit set; PENABLE=1 only in ACCESS.
REQ-024 error SHALL be meaningful only while ready=1 and SHALL be 0 otherwise.
REQ-025 PREADY/PSLVERR from non-selected completers and in IDLE/SETUP SHALL have no effect.

Reset
REQ-026 While PRESET=1, the block SHALL immediately drive state=IDLE and all outputs 0, with the timeout counter and latched request cleared.
REQ-027 Reset mid-transfer SHALL drop PSEL/PENABLE asynchronously and produce no ready pulse.

Verification
REQ-028 Write 0x1000_1004 data 0xDEAD_BEEF, PREADY[1]=1 immediately -> PSEL=4'b0010 for cycles 1-2, PENABLE in cycle 2 only, PWRITE=1, ready=1 with error=0 in cycle 3.
REQ-029 Read 0x1000_3000, PREADY[3] held low for 3 ACCESS cycles, then high with lane 3=0x1234_5678 -> rdata=0x1234_5678, ready one cycle after PREADY.
REQ-030 Read 0x0FFF_FFFC and 0x1000_4000 (NUM_SLV=4) -> PSEL stays 0, ready=1, error=1, rdata=0 one cycle after each transfer.
REQ-031 Read slave 0 with PREADY[0] stuck at 0, TIMEOUT_CYC=16 -> 16 ACCESS cycles, then IDLE; ready=1, error=1, rdata=0.
REQ-032 Write slave 2 returning PSLVERR=1 with PREADY -> ready=1, error=1; a back-to-back transfer issued in the ready cycle enters SETUP on the next edge.
REQ-033 PRESET pulsed during ACCESS -> PSEL=0 and PENABLE=0 immediately, no ready; the next transfer after reset completes normally.

Source files
------------

// File: rtl/apb_master_dec_if.sv
// APB bus bundle between the decoding master and its completers.
// PRDATA packs one DATA_W lane per completer; PSEL is one-hot.
interface apb_master_dec_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PWRITE;
  logic                      PENABLE;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_dec.sv
// APB requester with built-in address decode over NUM_SLV windows of 2**SLV_SHIFT bytes,
// per-access wait-state timeout, and a one-cycle ready/error completion pulse.
module apb_master_dec #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h1000_0000),
  parameter int                SLV_SHIFT   = 12,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_dec_if.master    apb,
  input  logic                transfer,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                write,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                error,
  output logic                busy
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;

  logic [ADDR_W-1:0]  off;
  logic [ADDR_W-1:0]  dec_full;
  logic               dec_valid;
  logic [IDX_W-1:0]   dec_idx;

  logic               accept;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic               done;
  logic               tmo;

  // Window index from the offset; addresses below the base wrap and are rejected by the compare.
  always_comb begin
    off       = addr - BASE_ADDR;
    dec_full  = off >> SLV_SHIFT;
    dec_valid = (addr >= BASE_ADDR) && (dec_full < ADDR_W'(NUM_SLV));
    dec_idx   = dec_full[IDX_W-1:0];
  end

  always_comb begin
    accept    = (state == IDLE) && transfer;
    sel_ready = apb.PREADY[idx];
    sel_err   = apb.PSLVERR[idx];
    sel_rdata = apb.PRDATA[int'(idx)*DATA_W +: DATA_W];
    cnt_inc   = cnt + 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE:   if (transfer && dec_valid) state_n = SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          state_n = IDLE;
          done    = 1'b1;
        end else if ((TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC))) begin
          state_n = IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus strobes are decoded from registered state so PRESET removes them without waiting for PCLK.
  always_comb begin
    apb.PSEL = '0;
    if (state != IDLE) apb.PSEL[idx] = 1'b1;
    apb.PENABLE = (state == ACCESS);
    busy        = (state != IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      apb.PADDR  <= '0;
      apb.PWDATA <= '0;
      apb.PWRITE <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      ready      <= 1'b0;
      error      <= 1'b0;
      rdata      <= '0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;

      if (accept) begin
        apb.PADDR  <= addr;
        apb.PWRITE <= write;
        apb.PWDATA <= write ? wdata : '0;
        idx        <= dec_idx;
        if (!dec_valid) begin
          ready <= 1'b1;
          error <= 1'b1;
          rdata <= '0;
        end
      end

      if (state == SETUP) cnt <= '0;
      else if ((state == ACCESS) && !sel_ready) cnt <= cnt_inc;

      if (done) begin
        ready <= 1'b1;
        error <= sel_err;
        if (!apb.PWRITE) rdata <= sel_err ? '0 : sel_rdata;
      end

      if (tmo) begin
        ready <= 1'b1;
        error <= 1'b1;
        if (!apb.PWRITE) rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_dec.sv
// Scenario bench for apb_master_dec: expected completions are queued at issue and
// popped when ready pulses; bus phases are checked cycle by cycle at the falling edge.
module tb_apb_master_dec;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          transfer;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          error;
  logic          busy;

  apb_master_dec_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

  apb_master_dec #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .BASE_ADDR(BASE),
    .SLV_SHIFT(12), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus.master),
    .transfer(transfer), .addr(addr), .wdata(wdata), .write(write),
    .ready(ready), .rdata(rdata), .error(error), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { logic [DW-1:0] rdata; logic err; } exp_t;
  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] m_rdata;

  task automatic test_reset();
    PRESET = 1'b1; transfer = 1'b0; addr = '0; wdata = '0; write = 1'b0;
    bus.PREADY = '0; bus.PSLVERR = '0; bus.PRDATA = '0;
    m_rdata = '0;
    repeat (2) @(negedge PCLK);
    vectors++; if (bus.PSEL !== 4'b0) begin miscompares++; $display("FAIL reset psel: got %b want 0000", bus.PSEL); end
    vectors++; if (bus.PENABLE !== 1'b0) begin miscompares++; $display("FAIL reset penable: got %b want 0", bus.PENABLE); end
    vectors++; if ({ready, error, busy} !== 3'b000) begin miscompares++; $display("FAIL reset rdy/err/busy: got %b want 000", {ready, error, busy}); end
    vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset rdata: got %h want 0", rdata); end
    vectors++; if (bus.PADDR !== '0 || bus.PWDATA !== '0 || bus.PWRITE !== 1'b0) begin
      miscompares++; $display("FAIL reset apb regs: got %h/%h/%b want 0", bus.PADDR, bus.PWDATA, bus.PWRITE); end
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  // Full zero-wait transfer; entered and left on the falling edge of a cycle where a request may be issued.
  task automatic test_zero_wait(input string nm, input logic [31:0] a, input logic [31:0] wd,
                                input logic wr, input logic [31:0] lane, input logic slverr);
    logic [31:0] tmp;
    int          idx;
    logic [3:0]  exp_psel;
    exp_t        e;
    tmp = a - BASE;
    idx = int'(tmp >> 12);
    exp_psel = 4'b0001 << idx;
    transfer = 1'b1; addr = a; wdata = wd; write = wr;
    bus.PREADY = exp_psel;
    bus.PSLVERR = slverr ? exp_psel : 4'b0;
    for (int i = 0; i < NS; i++) bus.PRDATA[i*DW +: DW] = (i == idx) ? lane : ~lane;
    if (!wr) m_rdata = slverr ? '0 : lane;
    sb.push_back('{m_rdata, slverr});
    @(negedge PCLK);
    transfer = 1'b0;
    vectors++; if (bus.PSEL !== exp_psel) begin miscompares++; $display("FAIL %s setup psel: got %b want %b", nm, bus.PSEL, exp_psel); end
    vectors++; if (bus.PENABLE !== 1'b0) begin miscompares++; $display("FAIL %s setup penable: got %b want 0", nm, bus.PENABLE); end
    vectors++; if (busy !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL %s setup busy/ready: got %b%b want 10", nm, busy, ready); end
    vectors++; if (bus.PADDR !== a) begin miscompares++; $display("FAIL %s paddr: got %h want %h", nm, bus.PADDR, a); end
    vectors++; if (bus.PWRITE !== wr) begin miscompares++; $display("FAIL %s pwrite: got %b want %b", nm, bus.PWRITE, wr); end
    vectors++; if (bus.PWDATA !== (wr ? wd : 32'h0)) begin miscompares++; $display("FAIL %s pwdata: got %h want %h", nm, bus.PWDATA, wr ? wd : 32'h0); end
    @(negedge PCLK);
    vectors++; if (bus.PSEL !== exp_psel || bus.PENABLE !== 1'b1) begin
      miscompares++; $display("FAIL %s access psel/penable: got %b/%b want %b/1", nm, bus.PSEL, bus.PENABLE, exp_psel); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL %s early ready: got %b want 0", nm, ready); end
    @(negedge PCLK);
    vectors++;
    if (ready !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL %s ready: got %b want 1 (queued %0d)", nm, ready, sb.size());
    end else begin
      e = sb.pop_front();
      vectors++; if (error !== e.err) begin miscompares++; $display("FAIL %s error: got %b want %b", nm, error, e.err); end
      vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL %s rdata: got %h want %h", nm, rdata, e.rdata); end
    end
    vectors++; if (bus.PSEL !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL %s idle psel/busy: got %b/%b want 0000/0", nm, bus.PSEL, busy); end
    bus.PREADY = '0; bus.PSLVERR = '0;
  endtask

  task automatic test_wait_read();
    exp_t e;
    transfer = 1'b1; addr = 32'h1000_3000; wdata = 32'h5555_5555; write = 1'b0;
    bus.PREADY = '0; bus.PSLVERR = '0;
    for (int i = 0; i < NS; i++) bus.PRDATA[i*DW +: DW] = (i == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF;
    m_rdata = 32'h1234_5678;
    sb.push_back('{m_rdata, 1'b0});
    @(negedge PCLK);
    // A competing invalid request and foreign ready/error lanes must all be ignored.
    transfer = 1'b1; addr = 32'h0000_0000; write = 1'b1;
    bus.PREADY = 4'b0111; bus.PSLVERR = 4'b0111;
    vectors++; if (bus.PSEL !== 4'b1000 || bus.PENABLE !== 1'b0) begin
      miscompares++; $display("FAIL wait_read setup psel/penable: got %b/%b want 1000/0", bus.PSEL, bus.PENABLE); end
    vectors++; if (bus.PWDATA !== 32'h0 || bus.PWRITE !== 1'b0) begin
      miscompares++; $display("FAIL wait_read pwdata/pwrite: got %h/%b want 0/0", bus.PWDATA, bus.PWRITE); end
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      vectors++; if (bus.PSEL !== 4'b1000 || bus.PENABLE !== 1'b1 || ready !== 1'b0) begin
        miscompares++; $display("FAIL wait_read wait%0d psel/penable/ready: got %b/%b/%b want 1000/1/0", i, bus.PSEL, bus.PENABLE, ready); end
      vectors++; if (bus.PADDR !== 32'h1000_3000) begin miscompares++; $display("FAIL wait_read paddr hold: got %h want 10003000", bus.PADDR); end
    end
    transfer = 1'b0; write = 1'b0;
    bus.PREADY = 4'b1000; bus.PSLVERR = 4'b0;
    @(negedge PCLK);
    vectors++;
    if (ready !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL wait_read ready: got %b want 1", ready);
    end else begin
      e = sb.pop_front();
      vectors++; if (error !== e.err) begin miscompares++; $display("FAIL wait_read error: got %b want %b", error, e.err); end
      vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL wait_read rdata: got %h want %h", rdata, e.rdata); end
    end
    bus.PREADY = '0;
  endtask

  task automatic test_decode_err();
    logic [31:0] bad [2];
    exp_t        e;
    bad[0] = 32'h0FFF_FFFC;
    bad[1] = 32'h1000_4000;
    for (int i = 0; i < 2; i++) begin
      transfer = 1'b1; addr = bad[i]; write = 1'b0;
      bus.PREADY = 4'b1111;
      m_rdata = '0;
      sb.push_back('{m_rdata, 1'b1});
      @(negedge PCLK);
      transfer = 1'b0;
      vectors++; if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL decode_err%0d psel/penable/busy: got %b/%b/%b want 0000/0/0", i, bus.PSEL, bus.PENABLE, busy); end
      vectors++;
      if (ready !== 1'b1 || sb.size() == 0) begin
        miscompares++; $display("FAIL decode_err%0d ready: got %b want 1", i, ready);
      end else begin
        e = sb.pop_front();
        vectors++; if (error !== e.err) begin miscompares++; $display("FAIL decode_err%0d error: got %b want %b", i, error, e.err); end
        vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL decode_err%0d rdata: got %h want %h", i, rdata, e.rdata); end
      end
    end
    bus.PREADY = '0;
  endtask

  task automatic test_timeout();
    int   n;
    exp_t e;
    transfer = 1'b1; addr = 32'h1000_0010; write = 1'b0;
    bus.PREADY = 4'b1110; bus.PSLVERR = '0;
    m_rdata = '0;
    sb.push_back('{m_rdata, 1'b1});
    @(negedge PCLK);
    transfer = 1'b0;
    vectors++; if (bus.PSEL !== 4'b0001) begin miscompares++; $display("FAIL timeout psel: got %b want 0001", bus.PSEL); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (bus.PENABLE !== 1'b1) break;
      n++;
    end
    vectors++; if (n != TO) begin miscompares++; $display("FAIL timeout access cycles: got %0d want %0d", n, TO); end
    vectors++;
    if (ready !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL timeout ready: got %b want 1", ready);
    end else begin
      e = sb.pop_front();
      vectors++; if (error !== e.err) begin miscompares++; $display("FAIL timeout error: got %b want %b", error, e.err); end
      vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL timeout rdata: got %h want %h", rdata, e.rdata); end
    end
    vectors++; if (busy !== 1'b0 || bus.PSEL !== 4'b0) begin miscompares++; $display("FAIL timeout idle busy/psel: got %b/%b want 0/0000", busy, bus.PSEL); end
    bus.PREADY = '0;
  endtask

  task automatic test_reset_mid();
    transfer = 1'b1; addr = 32'h1000_1000; write = 1'b0;
    bus.PREADY = '0; bus.PSLVERR = '0;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    vectors++; if (bus.PENABLE !== 1'b1) begin miscompares++; $display("FAIL reset_mid in access: got penable %b want 1", bus.PENABLE); end
    #2 PRESET = 1'b1;
    #1;
    vectors++; if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid async drop psel/penable/busy: got %b/%b/%b want 0000/0/0", bus.PSEL, bus.PENABLE, busy); end
    vectors++; if (bus.PADDR !== '0) begin miscompares++; $display("FAIL reset_mid paddr: got %h want 0", bus.PADDR); end
    bus.PREADY = 4'b0010;
    @(negedge PCLK);
    PRESET = 1'b0;
    m_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ready !== 1'b0 || error !== 1'b0) begin
        miscompares++; $display("FAIL reset_mid ready pulse %0d: got %b%b want 00", i, ready, error); end
      @(negedge PCLK);
    end
    bus.PREADY = '0;
  endtask

  initial begin
    test_reset();
    test_zero_wait("write_s1", 32'h1000_1004, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    test_wait_read();
    test_decode_err();
    test_zero_wait("read_s0", 32'h1000_0020, 32'hFFFF_0000, 1'b0, 32'h0BAD_F00D, 1'b0);
    test_timeout();
    test_zero_wait("read_s3", 32'h1000_3FFC, 32'h0, 1'b0, 32'h7777_0003, 1'b0);
    test_zero_wait("wr_slverr_s2", 32'h1000_2008, 32'h0000_00AA, 1'b1, 32'h0, 1'b1);
    test_zero_wait("back_to_back_s1", 32'h1000_1FFC, 32'h0, 1'b0, 32'hCAFE_0001, 1'b0);
    test_zero_wait("rd_slverr_s1", 32'h1000_1000, 32'h0, 1'b0, 32'h1111_2222, 1'b1);
    test_reset_mid();
    test_zero_wait("after_reset", 32'h1000_3004, 32'h0F0F_0F0F, 1'b1, 32'h0, 1'b0);
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
